// File: rtl/rcu_wdt.sv
// Watchdog timer: armed by en_i, fed with a key, drives the active-low reset
// request to the RCU for RST_HOLD cycles when a timeout is missed.
module rcu_wdt #(
  parameter int          CNT_WIDTH = 32,
  parameter int          PSC_WIDTH = 16,
  parameter int          RST_HOLD  = 16,
  parameter logic [31:0] FEED_KEY  = 32'h5A5A_A5A5
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic [PSC_WIDTH-1:0] psc_i,
  input  logic [CNT_WIDTH-1:0] load_i,
  input  logic [CNT_WIDTH-1:0] warn_i,
  input  logic                 feed_i,
  input  logic [31:0]          key_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 warn_irq_o,
  output logic                 wdt_rst_n_o,
  output logic [7:0]           evt_cnt_o
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [1:0] {IDLE, RUN, RST} state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [PSC_WIDTH-1:0] r_psc;
  logic [HW-1:0]        r_hold;
  logic                 r_warn;
  logic                 r_rst_n;
  logic [7:0]           r_evt;

  logic                 w_feed_ok;
  logic                 w_tick;
  logic                 w_load_zero;
  logic                 w_go_rst;
  logic                 w_hold_done;
  logic [CNT_WIDTH-1:0] w_cnt_dec;
  logic [7:0]           w_evt_inc;

  assign w_feed_ok   = feed_i && (key_i == FEED_KEY);
  assign w_tick      = (r_psc == psc_i);
  assign w_load_zero = (load_i == '0);
  assign w_cnt_dec   = r_cnt - CNT_WIDTH'(1);
  assign w_evt_inc   = (r_evt == 8'hFF) ? r_evt : r_evt + 8'd1;
  assign w_hold_done = (r_hold == HW'(RST_HOLD - 1));

  // Every path into RST: arm with zero load, feed with zero load, or the
  // last tick without a feed. Disable in RUN overrides all of them.
  always_comb begin
    w_go_rst = 1'b0;
    if (en_i) begin
      if (r_state == IDLE)
        w_go_rst = w_load_zero;
      else if (r_state == RUN)
        w_go_rst = w_feed_ok ? w_load_zero : (w_tick && r_cnt == CNT_WIDTH'(1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_psc   <= '0;
      r_hold  <= '0;
      r_warn  <= 1'b0;
      r_rst_n <= 1'b1;
      r_evt   <= '0;
    end else if (w_go_rst) begin
      r_state <= RST;
      r_cnt   <= '0;
      r_warn  <= 1'b0;
      r_rst_n <= 1'b0;
      r_evt   <= w_evt_inc;
      r_hold  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt   <= '0;
          r_warn  <= 1'b0;
          r_rst_n <= 1'b1;
          if (en_i) begin
            r_cnt   <= load_i;
            r_psc   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!en_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_warn  <= 1'b0;
          end else if (w_feed_ok) begin
            r_cnt  <= load_i;
            r_psc  <= '0;
            r_warn <= 1'b0;
          end else if (w_tick) begin
            r_psc <= '0;
            r_cnt <= w_cnt_dec;
            if (w_cnt_dec <= warn_i) r_warn <= 1'b1;
          end else begin
            r_psc <= r_psc + PSC_WIDTH'(1);
            if (r_cnt <= warn_i) r_warn <= 1'b1;
          end
        end
        RST: begin
          if (w_hold_done) begin
            r_rst_n <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cnt_o       = r_cnt;
  assign warn_irq_o  = r_warn;
  assign wdt_rst_n_o = r_rst_n;
  assign evt_cnt_o   = r_evt;

endmodule

// File: tb/tb_rcu_wdt.sv
// Directed bench for rcu_wdt: a vector table for cycle-exact behaviour plus
// hand-written sequences for long-running and reset corner cases.
module tb_rcu_wdt;

  localparam logic [31:0] K = 32'h5A5A_A5A5;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] psc;
  logic [31:0] load, warn;
  logic        feed;
  logic [31:0] key;
  logic [31:0] cnt;
  logic        warn_irq, wdt_rst_n;
  logic [7:0]  evt;

  int n_pass = 0;
  int n_tot  = 0;

  rcu_wdt dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .psc_i(psc), .load_i(load),
    .warn_i(warn), .feed_i(feed), .key_i(key), .cnt_o(cnt),
    .warn_irq_o(warn_irq), .wdt_rst_n_o(wdt_rst_n), .evt_cnt_o(evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [15:0] psc;
    logic [31:0] load, warn;
    logic        feed;
    logic [31:0] key;
    logic [31:0] e_cnt;
    logic        e_warn, e_rstn;
    logic [7:0]  e_evt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic e, logic [15:0] p, logic [31:0] l, logic [31:0] w,
                              logic f, logic [31:0] k, logic [31:0] ec, logic ew,
                              logic er, logic [7:0] ev);
    vec_t v;
    v.en = e; v.psc = p; v.load = l; v.warn = w; v.feed = f; v.key = k;
    v.e_cnt = ec; v.e_warn = ew; v.e_rstn = er; v.e_evt = ev;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 0; psc = 0; load = 0; warn = 0; feed = 0; key = 0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, lows;
    logic [31:0] mn;
    rst_n = 1'b1;

    // Expiry with psc=0, load=4, then 16-cycle hold
    tbl.push_back(mk(1, 0, 4, 0, 0, 0, 4, 0, 1, 0));
    tbl.push_back(mk(1, 0, 4, 0, 0, 0, 3, 0, 1, 0));
    tbl.push_back(mk(1, 0, 4, 0, 0, 0, 2, 0, 1, 0));
    tbl.push_back(mk(1, 0, 4, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 4, 0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 15; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    // Warning threshold, a wrong-key feed, a valid feed, disable beats feed
    tbl.push_back(mk(1, 0, 10, 3, 0, 0, 10, 0, 1, 1));
    for (int c = 9; c >= 6; c--) tbl.push_back(mk(1, 0, 10, 3, 0, 0, c, 0, 1, 1));
    tbl.push_back(mk(1, 0, 10, 3, 1, 0, 5, 0, 1, 1));
    tbl.push_back(mk(1, 0, 10, 3, 0, 0, 4, 0, 1, 1));
    tbl.push_back(mk(1, 0, 10, 3, 0, 0, 3, 1, 1, 1));
    tbl.push_back(mk(1, 0, 10, 3, 0, 0, 2, 1, 1, 1));
    tbl.push_back(mk(1, 0, 10, 3, 1, K, 10, 0, 1, 1));
    tbl.push_back(mk(1, 0, 10, 3, 0, 0, 9, 0, 1, 1));
    tbl.push_back(mk(0, 0, 10, 3, 1, K, 0, 0, 1, 1));
    // Feed wins over the expiring tick; feed with load 0 expires
    tbl.push_back(mk(1, 0, 2, 0, 0, 0, 2, 0, 1, 1));
    tbl.push_back(mk(1, 0, 2, 0, 0, 0, 1, 0, 1, 1));
    tbl.push_back(mk(1, 0, 5, 0, 1, K, 5, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, K, 0, 0, 0, 2));
    // Hold ignores en/feed; re-arm straight after release
    for (int i = 0; i < 15; i++) tbl.push_back(mk(1, 0, 5, 0, 1, K, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 5, 0, 1, K, 0, 0, 1, 2));
    tbl.push_back(mk(1, 0, 5, 0, 0, 0, 5, 0, 1, 2));
    tbl.push_back(mk(0, 0, 5, 0, 0, 0, 0, 0, 1, 2));
    // Warning raised on a non-tick cycle when count already below threshold
    tbl.push_back(mk(1, 3, 2, 5, 0, 0, 2, 0, 1, 2));
    tbl.push_back(mk(1, 3, 2, 5, 0, 0, 2, 1, 1, 2));
    tbl.push_back(mk(0, 3, 2, 5, 0, 0, 0, 0, 1, 2));

    do_reset();
    #1;
    chk("reset cnt", cnt, 0);
    chk("reset warn", 32'(warn_irq), 0);
    chk("reset rstn", 32'(wdt_rst_n), 1);
    chk("reset evt", 32'(evt), 0);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      en = tbl[i].en; psc = tbl[i].psc; load = tbl[i].load; warn = tbl[i].warn;
      feed = tbl[i].feed; key = tbl[i].key;
      edge1();
      chk($sformatf("vec%0d cnt", i), cnt, tbl[i].e_cnt);
      chk($sformatf("vec%0d warn", i), 32'(warn_irq), 32'(tbl[i].e_warn));
      chk($sformatf("vec%0d rstn", i), 32'(wdt_rst_n), 32'(tbl[i].e_rstn));
      chk($sformatf("vec%0d evt", i), 32'(evt), 32'(tbl[i].e_evt));
    end

    // Regular valid feeds keep the watchdog quiet for 1000 cycles
    do_reset();
    @(posedge clk); #1;
    en = 1; psc = 2; load = 3; warn = 0; key = K; feed = 0;
    edge1();
    mn = cnt; lows = 0;
    for (int i = 1; i <= 1000; i++) begin
      feed = (i % 6 == 0);
      edge1();
      if (cnt < mn) mn = cnt;
      if (!wdt_rst_n) lows++;
    end
    feed = 0;
    chk("feed rstn lows", 32'(lows), 0);
    chk("feed min cnt", mn, 2);
    chk("feed evt", 32'(evt), 0);

    // Wrong key: expiry after 9 RUN cycles
    do_reset();
    @(posedge clk); #1;
    en = 1; psc = 2; load = 3; feed = 1; key = 32'h0;
    edge1();
    n = 0;
    while (wdt_rst_n && n < 100) begin
      edge1();
      n++;
    end
    chk("wrongkey cycles", 32'(n), 9);
    chk("wrongkey evt", 32'(evt), 1);

    // Async reset mid-hold releases the request immediately
    repeat (5) edge1();
    chk("midhold rstn low", 32'(wdt_rst_n), 0);
    en = 0; feed = 0;
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midhold rstn", 32'(wdt_rst_n), 1);
    chk("midhold evt", 32'(evt), 0);
    chk("midhold cnt", cnt, 0);
    @(negedge clk) rst_n = 1'b1;

    // load=0 at arm goes straight to RST; repeated expiries saturate evt
    @(posedge clk); #1;
    en = 1; psc = 0; load = 0; key = 0;
    edge1();
    chk("load0 rstn", 32'(wdt_rst_n), 0);
    chk("load0 evt", 32'(evt), 1);
    chk("load0 cnt", cnt, 0);
    repeat (17 * 253) edge1();
    chk("evt 254", 32'(evt), 254);
    repeat (17 * 50) edge1();
    chk("evt saturate", 32'(evt), 255);
    en = 0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
